memio_responder: RTL and testbench

- Bus-side responder for the multicycle CPU's load/store requests.
- Accepts one memory or IO request at a time: read/write strobe, address, width, sign.
- Checks alignment and drives a synchronous RAM with byte enables, or the 1 KB IO window at 0xFFFFFC00–0xFFFFFFFF.
- Returns sign- or zero-extended load data with a one-cycle done pulse.

---
 rtl/memio_responder_if.sv | 41 ++++
 rtl/memio_responder.sv | 158 +++++++++++++++
 tb/tb_memio_responder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/memio_responder_if.sv
// Load/store request, RAM and IO signals between the CPU, memio_responder and the memories.
// The responder takes the slave view; the CPU/memory side takes the master view.
interface memio_responder_if;
  logic        req_mem_read;
  logic        req_mem_write;
  logic        req_io_read;
  logic        req_io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  data_width;
  logic        data_sign;
  logic        busy;
  logic        done;
  logic        addr_err;
  logic [31:0] rdata;
  logic [29:0] ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [9:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata;

  modport slave (
    input  req_mem_read, req_mem_write, req_io_read, req_io_write,
           addr, wdata, data_width, data_sign, ram_rdata, io_rdata,
    output busy, done, addr_err, rdata, ram_addr, ram_re, ram_we, ram_be,
           ram_wdata, io_addr, io_rd, io_wr, io_wdata
  );

  modport master (
    output req_mem_read, req_mem_write, req_io_read, req_io_write,
           addr, wdata, data_width, data_sign, ram_rdata, io_rdata,
    input  busy, done, addr_err, rdata, ram_addr, ram_re, ram_we, ram_be,
           ram_wdata, io_addr, io_rd, io_wr, io_wdata
  );
endinterface

// File: rtl/memio_responder.sv
// Single-outstanding load/store responder: alignment check, RAM byte lanes, 1 KB IO window,
// extended load data. Latency WAIT+1 cycles to done (2 on error); requests seen while busy are dropped.
module memio_responder #(
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned IO_WAIT  = 1
) (
  input logic               clock,
  input logic               reset,
  memio_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] MEM_LAST = 8'(MEM_WAIT - 1);
  localparam logic [7:0] IO_LAST  = 8'(IO_WAIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  width_q, width_d;
  logic        sign_q, sign_d;
  logic        is_io_q, is_io_d;
  logic        is_wr_q, is_wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic        req_is_io;
  logic        misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_val;
  logic [3:0]  be_val;
  logic [31:0] wlane_val;
  logic        mem_acc;
  logic        first;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      sign_q  <= 1'b0;
      is_io_q <= 1'b0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      sign_q  <= sign_d;
      is_io_q <= is_io_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign any_req   = bus.req_mem_read | bus.req_mem_write | bus.req_io_read | bus.req_io_write;
  assign req_is_io = ~bus.req_mem_write & ~bus.req_mem_read;
  assign misalign  = (bus.data_width == 2'b10) ||
                     (bus.data_width == 2'b01 && bus.addr[0]) ||
                     (bus.data_width == 2'b11 && bus.addr[1:0] != 2'b00);

  // Load lane extraction and extension from the latched address/width/sign
  always_comb begin
    ld_byte  = '0;
    ld_half  = bus.ram_rdata[15:0];
    load_val = bus.ram_rdata;
    case (addr_q[1:0])
      2'd0:    ld_byte = bus.ram_rdata[7:0];
      2'd1:    ld_byte = bus.ram_rdata[15:8];
      2'd2:    ld_byte = bus.ram_rdata[23:16];
      default: ld_byte = bus.ram_rdata[31:24];
    endcase
    if (addr_q[1]) ld_half = bus.ram_rdata[31:16];
    if (is_io_q)
      load_val = {16'h0000, bus.io_rdata};
    else if (width_q == 2'b00)
      load_val = {{24{sign_q & ld_byte[7]}}, ld_byte};
    else if (width_q == 2'b01)
      load_val = {{16{sign_q & ld_half[15]}}, ld_half};
  end

  always_comb begin
    be_val    = 4'b1111;
    wlane_val = wdata_q;
    if (width_q == 2'b00) begin
      be_val    = 4'b0001 << addr_q[1:0];
      wlane_val = {4{wdata_q[7:0]}};
    end else if (width_q == 2'b01) begin
      be_val    = addr_q[1] ? 4'b1100 : 4'b0011;
      wlane_val = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    sign_d  = sign_q;
    is_io_d = is_io_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          width_d = bus.data_width;
          sign_d  = bus.data_sign;
          is_io_d = req_is_io;
          is_wr_d = bus.req_mem_write | (~bus.req_mem_read & bus.req_io_write);
          err_d   = ~req_is_io & misalign;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Errored requests spend one strobe-less cycle here so done lands at the same edge count as WAIT=1
        if (err_q) begin
          state_d = RESP;
        end else if (cnt_q == (is_io_q ? IO_LAST : MEM_LAST)) begin
          if (!is_wr_q) rdata_d = load_val;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_acc = (state_q == ACCESS) & ~is_io_q & ~err_q;
  assign first   = (cnt_q == 8'd0);

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == RESP);
  assign bus.addr_err  = (state_q == RESP) & err_q;
  assign bus.rdata     = rdata_q;
  assign bus.ram_addr  = addr_q[31:2];
  assign bus.ram_re    = mem_acc & first & ~is_wr_q;
  assign bus.ram_we    = mem_acc & first & is_wr_q;
  assign bus.ram_be    = (mem_acc & is_wr_q) ? be_val : 4'b0000;
  assign bus.ram_wdata = (mem_acc & is_wr_q) ? wlane_val : 32'h0;
  assign bus.io_addr   = addr_q[9:0];
  assign bus.io_rd     = (state_q == ACCESS) & is_io_q & first & ~is_wr_q;
  assign bus.io_wr     = (state_q == ACCESS) & is_io_q & first & is_wr_q;
  assign bus.io_wdata  = wdata_q[15:0];
endmodule

// File: tb/tb_memio_responder.sv
// Directed bench for memio_responder (MEM_WAIT=2, IO_WAIT=1); inputs change and outputs are
// sampled on the falling edge, away from the rising edge the design uses.
module tb_memio_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  memio_responder_if bus();

  memio_responder #(.MEM_WAIT(2), .IO_WAIT(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Drives one request across the next rising edge (edge N), then drops the strobes.
  task automatic issue(input logic mr, input logic mw, input logic ir, input logic iw,
                       input logic [31:0] a, input logic [31:0] w,
                       input logic [1:0] wd, input logic s);
    bus.req_mem_read  = mr;
    bus.req_mem_write = mw;
    bus.req_io_read   = ir;
    bus.req_io_write  = iw;
    bus.addr          = a;
    bus.wdata         = w;
    bus.data_width    = wd;
    bus.data_sign     = s;
    @(posedge clock);
    #1;
    bus.req_mem_read  = 1'b0;
    bus.req_mem_write = 1'b0;
    bus.req_io_read   = 1'b0;
    bus.req_io_write  = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({bus.busy, bus.done, bus.addr_err, bus.ram_re, bus.ram_we, bus.io_rd, bus.io_wr} !== 7'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=0", {bus.busy, bus.done, bus.addr_err, bus.ram_re, bus.ram_we, bus.io_rd, bus.io_wr});
    end
    total++;
    if ({bus.rdata, bus.ram_addr, bus.ram_be, bus.ram_wdata, bus.io_addr, bus.io_wdata} !== '0) begin
      bad++; $display("FAIL reset_buses got rdata=%h ram_addr=%h be=%b want all 0", bus.rdata, bus.ram_addr, bus.ram_be);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_word_load();
    bus.ram_rdata = 32'hDEADBEEF;
    issue(1, 0, 0, 0, 32'h0000_0104, 32'h0, 2'b11, 1'b0);
    @(negedge clock);
    total++;
    if ({bus.ram_re, bus.busy, bus.done, bus.ram_be} !== 7'b1100000 || bus.ram_addr !== 30'h41) begin
      bad++; $display("FAIL wload_strobe got re=%b busy=%b done=%b be=%b addr=%h want 1 1 0 0000 41", bus.ram_re, bus.busy, bus.done, bus.ram_be, bus.ram_addr);
    end
    @(negedge clock);
    total++;
    if (bus.ram_re !== 1'b0 || bus.done !== 1'b0 || bus.ram_addr !== 30'h41) begin
      bad++; $display("FAIL wload_hold got re=%b done=%b addr=%h want 0 0 41", bus.ram_re, bus.done, bus.ram_addr);
    end
    @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.addr_err !== 1'b0 || bus.rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL wload_done got done=%b err=%b rdata=%h want 1 0 deadbeef", bus.done, bus.addr_err, bus.rdata);
    end
    @(negedge clock);
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL wload_idle got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_sub_loads();
    logic [31:0] addrs [4]  = '{32'h103, 32'h103, 32'h102, 32'h101};
    logic        signs [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] wants [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFFF, 32'h0000007F};
    bus.ram_rdata = 32'h80FF7F01;
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 0, 0, addrs[i], 32'h0, 2'b00, signs[i]);
      repeat (3) @(negedge clock);
      total++;
      if (bus.done !== 1'b1 || bus.rdata !== wants[i]) begin
        bad++; $display("FAIL byte_load%0d got done=%b rdata=%h want 1 %h", i, bus.done, bus.rdata, wants[i]);
      end
      @(negedge clock);
    end
    issue(1, 0, 0, 0, 32'h102, 32'h0, 2'b01, 1'b1);
    repeat (3) @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'hFFFF80FF) begin
      bad++; $display("FAIL half_load got done=%b rdata=%h want 1 ffff80ff", bus.done, bus.rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_stores();
    issue(0, 1, 0, 0, 32'h0000_0202, 32'h0000ABCD, 2'b01, 1'b0);
    @(negedge clock);
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_re !== 1'b0 || bus.ram_be !== 4'b1100 || bus.ram_wdata !== 32'hABCDABCD || bus.ram_addr !== 30'h80) begin
      bad++; $display("FAIL hstore_lanes got we=%b re=%b be=%b wd=%h addr=%h want 1 0 1100 abcdabcd 80", bus.ram_we, bus.ram_re, bus.ram_be, bus.ram_wdata, bus.ram_addr);
    end
    @(negedge clock);
    total++;
    if (bus.ram_we !== 1'b0 || bus.ram_be !== 4'b1100 || bus.ram_wdata !== 32'hABCDABCD) begin
      bad++; $display("FAIL hstore_hold got we=%b be=%b wd=%h want 0 1100 abcdabcd", bus.ram_we, bus.ram_be, bus.ram_wdata);
    end
    @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'hFFFF80FF) begin
      bad++; $display("FAIL hstore_done got done=%b rdata=%h want 1 ffff80ff", bus.done, bus.rdata);
    end
    @(negedge clock);
    issue(0, 1, 0, 0, 32'h0000_0301, 32'h0000_0012, 2'b00, 1'b0);
    @(negedge clock);
    total++;
    if (bus.ram_we !== 1'b1 || bus.ram_be !== 4'b0010 || bus.ram_wdata !== 32'h12121212) begin
      bad++; $display("FAIL bstore_lanes got we=%b be=%b wd=%h want 1 0010 12121212", bus.ram_we, bus.ram_be, bus.ram_wdata);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_misalign();
    logic [31:0] addrs  [2] = '{32'h0000_0102, 32'h0000_0100};
    logic [1:0]  widths [2] = '{2'b11, 2'b10};
    for (int i = 0; i < 2; i++) begin
      issue(1, 0, 0, 0, addrs[i], 32'h0, widths[i], 1'b0);
      @(negedge clock);
      total++;
      if (bus.ram_re !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        bad++; $display("FAIL misalign%0d_first got re=%b done=%b busy=%b want 0 0 1", i, bus.ram_re, bus.done, bus.busy);
      end
      @(negedge clock);
      total++;
      if (bus.done !== 1'b1 || bus.addr_err !== 1'b1 || bus.rdata !== 32'hFFFF80FF) begin
        bad++; $display("FAIL misalign%0d_resp got done=%b err=%b rdata=%h want 1 1 ffff80ff", i, bus.done, bus.addr_err, bus.rdata);
      end
      @(negedge clock);
      total++;
      if (bus.done !== 1'b0 || bus.addr_err !== 1'b0) begin
        bad++; $display("FAIL misalign%0d_after got done=%b err=%b want 0 0", i, bus.done, bus.addr_err);
      end
    end
  endtask

  task automatic test_io();
    bus.io_rdata = 16'h8001;
    issue(0, 0, 1, 0, 32'hFFFF_FC10, 32'h0, 2'b10, 1'b1);
    @(negedge clock);
    total++;
    if (bus.io_rd !== 1'b1 || bus.io_addr !== 10'h010 || bus.ram_re !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL io_read_strobe got rd=%b addr=%h ram_re=%b done=%b want 1 010 0 0", bus.io_rd, bus.io_addr, bus.ram_re, bus.done);
    end
    @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.addr_err !== 1'b0 || bus.rdata !== 32'h00008001) begin
      bad++; $display("FAIL io_read_done got done=%b err=%b rdata=%h want 1 0 00008001", bus.done, bus.addr_err, bus.rdata);
    end
    @(negedge clock);
    issue(0, 0, 0, 1, 32'hFFFF_FFFE, 32'h1234_5678, 2'b00, 1'b0);
    @(negedge clock);
    total++;
    if (bus.io_wr !== 1'b1 || bus.io_addr !== 10'h3FE || bus.io_wdata !== 16'h5678 || bus.ram_we !== 1'b0) begin
      bad++; $display("FAIL io_write got wr=%b addr=%h wd=%h ram_we=%b want 1 3fe 5678 0", bus.io_wr, bus.io_addr, bus.io_wdata, bus.ram_we);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_priority();
    issue(0, 1, 1, 0, 32'h0000_0400, 32'hCAFEF00D, 2'b11, 1'b0);
    @(negedge clock);
    total++;
    if (bus.ram_we !== 1'b1 || bus.io_rd !== 1'b0 || bus.ram_re !== 1'b0 || bus.ram_wdata !== 32'hCAFEF00D || bus.ram_be !== 4'b1111) begin
      bad++; $display("FAIL priority got we=%b io_rd=%b re=%b wd=%h be=%b want 1 0 0 cafef00d 1111", bus.ram_we, bus.io_rd, bus.ram_re, bus.ram_wdata, bus.ram_be);
    end
    @(negedge clock);
    @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'h00008001) begin
      bad++; $display("FAIL priority_done got done=%b rdata=%h want 1 00008001", bus.done, bus.rdata);
    end
    @(negedge clock);
  endtask

  task automatic test_busy_drop();
    int dones = 0;
    int iords = 0;
    bus.ram_rdata = 32'h0BAD_F00D;
    issue(1, 0, 0, 0, 32'h0000_0008, 32'h0, 2'b11, 1'b0);
    @(negedge clock);
    bus.req_io_read = 1'b1;
    bus.addr        = 32'hFFFF_FC20;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL busy_flag got=%b want 1", bus.busy);
    end
    @(posedge clock);
    #1 bus.req_io_read = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) dones++;
      if (bus.io_rd === 1'b1) iords++;
    end
    total++;
    if (dones != 1 || iords != 0 || bus.rdata !== 32'h0BADF00D) begin
      bad++; $display("FAIL busy_drop got dones=%0d io_rd=%0d rdata=%h want 1 0 0badf00d", dones, iords, bus.rdata);
    end
  endtask

  task automatic test_reset_mid();
    bus.ram_rdata = 32'h80FF7F01;
    issue(1, 0, 0, 0, 32'h0000_0104, 32'h0, 2'b11, 1'b0);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.addr_err, bus.ram_re, bus.ram_we, bus.io_rd, bus.io_wr} !== 7'b0 || bus.rdata !== 32'h0 || bus.ram_addr !== 30'h0) begin
      bad++; $display("FAIL reset_mid got busy=%b re=%b rdata=%h addr=%h want all 0", bus.busy, bus.ram_re, bus.rdata, bus.ram_addr);
    end
    @(negedge clock);
    reset = 1'b1;
    issue(1, 0, 0, 0, 32'h0000_0102, 32'h0, 2'b00, 1'b0);
    @(negedge clock);
    total++;
    if (bus.ram_re !== 1'b1 || bus.ram_addr !== 30'h40) begin
      bad++; $display("FAIL reset_resume_strobe got re=%b addr=%h want 1 40", bus.ram_re, bus.ram_addr);
    end
    repeat (2) @(negedge clock);
    total++;
    if (bus.done !== 1'b1 || bus.rdata !== 32'h000000FF) begin
      bad++; $display("FAIL reset_resume_done got done=%b rdata=%h want 1 000000ff", bus.done, bus.rdata);
    end
    @(negedge clock);
  endtask

  initial begin
    bus.req_mem_read  = 1'b0;
    bus.req_mem_write = 1'b0;
    bus.req_io_read   = 1'b0;
    bus.req_io_write  = 1'b0;
    bus.addr          = '0;
    bus.wdata         = '0;
    bus.data_width    = 2'b00;
    bus.data_sign     = 1'b0;
    bus.ram_rdata     = '0;
    bus.io_rdata      = '0;
    test_reset();
    test_word_load();
    test_sub_loads();
    test_stores();
    test_misalign();
    test_io();
    test_priority();
    test_busy_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
